// File: rtl/gcd_requester.sv
// Initiator-side controller for the binary-GCD engine: valid/ready requests in,
// engine start/done handshake, latency-tagged valid/ready responses out, zero-operand bypass and watchdog.
module gcd_requester #(
   parameter int W       = 32,
   parameter int CW      = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [W-1:0]  s_a,
   input  logic [W-1:0]  s_b,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [W-1:0]  m_gcd,
   output logic [CW-1:0] m_cycles,
   output logic          m_zero_err,
   output logic          fault,
   output logic          eng_start,
   output logic [W-1:0]  eng_a,
   output logic [W-1:0]  eng_b,
   input  logic          eng_ready,
   input  logic          eng_done_tick,
   input  logic [W-1:0]  eng_r
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPTURE,
      S_RESP,
      S_FAULT
   } state_t;

   localparam logic [CW-1:0] LP_TIMEOUT = CW'(TIMEOUT);
   localparam logic [CW-1:0] LP_CNT_MAX = '1;

   state_t        r_state;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_res;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_cyc;
   logic          r_zero;
   logic          r_valid;
   logic          r_fault;
   logic          w_a_zero;
   logic          w_b_zero;

   assign w_a_zero = (s_a == '0);
   assign w_b_zero = (s_b == '0);

   // Start must coincide with the engine's ready cycle, so it is decoded rather than registered;
   // the async reset forces IDLE, which drops it immediately.
   assign eng_start  = (r_state == S_ISSUE) && eng_ready;
   assign s_ready    = (r_state == S_IDLE) && !reset;
   assign eng_a      = r_a;
   assign eng_b      = r_b;
   assign m_valid    = r_valid;
   assign m_gcd      = r_res;
   assign m_cycles   = r_cyc;
   assign m_zero_err = r_zero;
   assign fault      = r_fault;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_cyc   <= '0;
         r_zero  <= 1'b0;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (s_valid) begin
                  r_a <= s_a;
                  r_b <= s_b;
                  if (w_a_zero || w_b_zero) begin
                     r_res   <= w_a_zero ? s_b : s_a;
                     r_zero  <= w_a_zero && w_b_zero;
                     r_cyc   <= '0;
                     r_valid <= 1'b1;
                     r_state <= S_RESP;
                  end else begin
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (eng_ready) begin
                  r_cnt   <= CW'(1);
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (eng_done_tick) begin
                  r_cyc   <= r_cnt;
                  r_state <= S_CAPTURE;
               end else if (r_cnt == LP_TIMEOUT) begin
                  r_fault <= 1'b1;
                  r_state <= S_FAULT;
               end else if (r_cnt != LP_CNT_MAX) begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            // Engine result settles one cycle after its done tick.
            S_CAPTURE: begin
               r_res   <= eng_r;
               r_zero  <= 1'b0;
               r_valid <= 1'b1;
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (m_ready) begin
                  r_valid <= 1'b0;
                  r_zero  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_FAULT: begin
               r_fault <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a behavioural binary-GCD engine and a response scoreboard.
module tb_gcd_requester;

   localparam int W  = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  s_a;
   logic [W-1:0]  s_b;
   logic          m_valid;
   logic          m_ready;
   logic [W-1:0]  m_gcd;
   logic [CW-1:0] m_cycles;
   logic          m_zero_err;
   logic          fault;
   logic          eng_start;
   logic [W-1:0]  eng_a;
   logic [W-1:0]  eng_b;
   logic          eng_ready;
   logic          eng_done_tick;
   logic [W-1:0]  eng_r;

   always #5 clk = ~clk;

   gcd_requester #(.W(W), .CW(CW), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .m_valid(m_valid), .m_ready(m_ready), .m_gcd(m_gcd), .m_cycles(m_cycles),
      .m_zero_err(m_zero_err), .fault(fault),
      .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
      .eng_ready(eng_ready), .eng_done_tick(eng_done_tick), .eng_r(eng_r)
   );

   // Engine model: one binary-GCD step per cycle, done while operands are equal,
   // result (a << k) appears one cycle after the done tick.
   logic         e_busy;
   logic         e_hang;
   logic         eng_clr;
   logic [W-1:0] ea, eb;
   int           ek;

   assign eng_ready     = !e_busy;
   assign eng_done_tick = e_busy && (ea == eb) && !e_hang;

   always @(posedge clk or posedge eng_clr) begin
      if (eng_clr) begin
         e_busy <= 1'b0;
         ea     <= '0;
         eb     <= '0;
         ek     <= 0;
         eng_r  <= '0;
      end else if (!e_busy) begin
         if (eng_start) begin
            e_busy <= 1'b1;
            ea     <= eng_a;
            eb     <= eng_b;
            ek     <= 0;
         end
      end else if (eng_done_tick) begin
         eng_r  <= ea << ek;
         e_busy <= 1'b0;
      end else if (ea != eb) begin
         if (!ea[0] && !eb[0]) begin
            ea <= ea >> 1;
            eb <= eb >> 1;
            ek <= ek + 1;
         end else if (!ea[0]) ea <= ea >> 1;
         else if (!eb[0])     eb <= eb >> 1;
         else if (ea > eb)    ea <= ea - eb;
         else                 eb <= eb - ea;
      end
   end

   int n_start = 0;
   always @(posedge clk) if (eng_start) n_start++;

   typedef struct {
      logic [W-1:0]  gcd;
      logic [CW-1:0] cyc;
      logic          zero;
   } exp_t;
   exp_t q[$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b);
      for (int i = 0; i < 40 && !s_ready; i++) @(negedge clk);
      s_valid = 1'b1;
      s_a     = a;
      s_b     = b;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] g, input logic [CW-1:0] c, input logic z);
      exp_t e;
      e.gcd = g; e.cyc = c; e.zero = z;
      q.push_back(e);
      drive_req(a, b);
   endtask

   task automatic recv(input string tag, input int hold);
      exp_t e;
      for (int i = 0; i < 40 && !m_valid; i++) @(negedge clk);
      chk({tag, "_valid"}, m_valid, 1);
      if (q.size() == 0) begin
         chk({tag, "_sb_empty"}, q.size(), 1);
      end else begin
         e = q.pop_front();
         chk({tag, "_gcd"}, m_gcd, e.gcd);
         chk({tag, "_cycles"}, m_cycles, e.cyc);
         chk({tag, "_zero"}, m_zero_err, e.zero);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == hold - 1 || i == hold / 2) begin
               chk({tag, "_hold_valid"}, m_valid, 1);
               chk({tag, "_hold_gcd"}, m_gcd, e.gcd);
               chk({tag, "_hold_sready"}, s_ready, 0);
            end
         end
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk({tag, "_valid_drop"}, m_valid, 0);
      chk({tag, "_sready_back"}, s_ready, 1);
   endtask

   int st;

   initial begin
      reset = 1'b1; eng_clr = 1'b1; e_hang = 1'b0;
      s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sready", s_ready, 0);
      chk("rst_mvalid", m_valid, 0);
      chk("rst_fault", fault, 0);
      chk("rst_start", eng_start, 0);
      chk("rst_eng_a", eng_a, 0);
      reset = 1'b0; eng_clr = 1'b0;
      @(negedge clk);
      chk("idle_sready", s_ready, 1);

      st = n_start;
      send(12, 18, 6, 5, 0);
      recv("g12_18", 0);
      chk("g12_18_starts", n_start - st, 1);

      send(7, 7, 7, 1, 0);
      recv("g7_7", 0);

      st = n_start;
      send(0, 9, 9, 0, 0);
      recv("g0_9", 0);
      send(0, 0, 0, 0, 1);
      recv("g0_0", 0);
      send(15, 0, 15, 0, 0);
      recv("g15_0", 0);
      chk("bypass_starts", n_start - st, 0);

      send(48, 36, 12, 7, 0);
      recv("g48_36", 10);

      // Reset while waiting on the engine; its late done tick must not produce a response.
      drive_req(48, 36);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_start", eng_start, 0);
      chk("midrst_sready", s_ready, 0);
      reset = 1'b0;
      for (int i = 0; i < 20 && !eng_done_tick; i++) @(negedge clk);
      chk("stale_done_seen", eng_done_tick, 1);
      chk("stale_sready", s_ready, 1);
      repeat (3) @(negedge clk);
      chk("stale_mvalid", m_valid, 0);
      send(10, 4, 2, 6, 0);
      recv("g10_4", 0);

      // Hung engine: counter reaches TIMEOUT in the 8th cycle after start, fault registers on that edge.
      e_hang = 1'b1;
      drive_req(5, 3);
      for (int i = 0; i < 10 && !eng_start; i++) @(negedge clk);
      chk("hang_start", eng_start, 1);
      repeat (8) @(negedge clk);
      chk("fault_not_yet", fault, 0);
      @(negedge clk);
      chk("fault_set", fault, 1);
      chk("fault_sready", s_ready, 0);
      repeat (5) @(negedge clk);
      chk("fault_sticky", fault, 1);
      chk("fault_mvalid", m_valid, 0);
      chk("fault_sready2", s_ready, 0);
      reset = 1'b1; eng_clr = 1'b1; e_hang = 1'b0;
      @(negedge clk);
      reset = 1'b0; eng_clr = 1'b0;
      @(negedge clk);
      chk("fault_cleared", fault, 0);
      chk("post_fault_sready", s_ready, 1);
      send(21, 14, 7, 4, 0);
      recv("g21_14", 0);

      chk("sb_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
